cmsdk_ahb_sram_arbiter: RTL and testbench
=========================================

CMSDK_AHB_SRAM_ARBITER -- requirements
Module: cmsdk_ahb_sram_arbiter

Shares one AHB-Lite SRAM slave port between master 0 (CPU system bus) and master 1 (DMA). Packed per-master vectors: index [i] / slice i belongs to master i.

Interface
REQ-001 Parameter AW, default 16: address width presented to slave.
REQ-002 Parameter ROUND_ROBIN, default 1: 1 = round-robin arbitration; 0 = fixed priority, master 0 highest.
REQ-003 HCLK  input  1  sole clock; all state on rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 HSELM  input  2  per-master slave select.
REQ-006 HADDRM  input  2*AW  per-master address.
REQ-007 HTRANSM  input  4  per-master HTRANS.
REQ-008 HSIZEM  input  6  per-master HSIZE.
REQ-009 HWRITEM  input  2  per-master HWRITE.
REQ-010 HWDATAM  input  64  per-master write data.
REQ-011 HREADYM  input  2  per-master bus HREADY; equals that master's HREADYOUTM at system level.
REQ-012 HREADYOUTM  output  2  per-master ready.
REQ-013 HRDATAM  output  64  per-master read data.
REQ-014 HRESPM  output  2  per-master response.
REQ-015 HSELS, HADDRS[AW-1:0], HTRANSS[1:0], HSIZES[2:0], HWRITES, HWDATAS[31:0], HREADYS  output  slave-side AHB-Lite request signals.
REQ-016 HREADYOUTS  input  1; HRDATAS  input  32; HRESPS  input  1  slave response.

Function
REQ-017 Live request: live_i = HSELM[i] & HTRANSM[i][1] & HREADYM[i].
REQ-018 Request: req_i = live_i | (state_i == WAIT).
REQ-019 Per-master FSM states: IDLE, WAIT (address phase captured, not yet issued), DATA (data phase on slave).
REQ-020 Grants are issued only in cycles with HREADYOUTS = 1; at most one grant per cycle.
REQ-021 Arbitration, single requester: grant it.
REQ-022 Arbitration, both requesting, ROUND_ROBIN = 1: grant the master not granted most recently.
REQ-023 Arbitration, both requesting, ROUND_ROBIN = 0: grant master 0.
REQ-024 On a live request, each master's address/control (HADDRM, HSIZEM, HWRITEM) is captured into a per-master pending register when not granted that cycle.
REQ-025 Granted master's address/control reach the slave side combinationally, from the pending register if state WAIT, else from the live inputs.
REQ-026 Slave side on grant: HSELS = 1, HTRANSS = 2'b10; SEQ is always converted to NONSEQ.
REQ-027 Slave side with no grant: HSELS = 0, HTRANSS = 2'b00.
REQ-028 HREADYS = HREADYOUTS.
REQ-029 Transition IDLE -> DATA: live & granted.
REQ-030 Transition IDLE -> WAIT: live & not granted.
REQ-031 Transition WAIT -> DATA: granted.
REQ-032 Transitions from DATA when HREADYOUTS = 1: -> DATA if live & granted; -> WAIT if live & not granted; -> IDLE if no live request.
REQ-033 DATA holds while HREADYOUTS = 0.
REQ-034 HREADYOUTM[i] by state: IDLE = 1; WAIT = 0; DATA = HREADYOUTS.
REQ-035 HRESPM[i] = HRESPS in DATA, else 0; a two-cycle ERROR passes through unchanged.
REQ-036 HRDATAM[i] = HRDATAS for both masters.
REQ-037 HWDATAS = HWDATAM of the master in DATA, else 0; at most one master is in DATA at any time.
REQ-038 Latency: uncontended transfer adds 0 cycles; a losing request adds one cycle per competing transfer ahead of it.
REQ-039 Last-grant register updates on every grant.
REQ-040 HTRANSM = BUSY (2'b01) is not a request and is never forwarded.

Reset
REQ-041 HRESET asserted at any time immediately clears, without a clock: both FSMs to IDLE, pending registers to 0, last-grant to master 1 (master 0 wins the first tie).
REQ-042 Outputs during reset: HREADYOUTM = 2'b11, HRESPM = 0, HSELS = 0, HTRANSS = 0, HWDATAS = 0.
REQ-043 Any in-flight or WAIT transfer is abandoned on reset; nothing is replayed after reset.

Verification
REQ-044 M0 NONSEQ read 0x0100, zero-wait slave -> same cycle HSELS = 1, HADDRS = 0x0100, HTRANSS = 10; next cycle HRDATAM[31:0] = HRDATAS, HREADYOUTM[0] = 1.
REQ-045 Both masters NONSEQ in cycle 0 after reset, RR -> M0 issued in cycle 0; M1 enters WAIT with HREADYOUTM[1] = 0 in cycle 1; M1 address issued in cycle 1 from pending register; M1 completes in cycle 2.
REQ-046 Both masters issue continuous 4-beat SEQ bursts, RR -> slave grant order 0,1,0,1,...; all HTRANSS = 10; each master sees exactly one wait state per beat.
REQ-047 ROUND_ROBIN = 0, M0 continuous, M1 requests -> M1 held in WAIT until the first cycle M0 has no request, then granted.
REQ-048 Slave inserts 2 wait states on an M0 write; M1 issues during them -> M1 in WAIT; HWDATAS = M0 data until HREADYOUTS = 1; M1 then granted; HWDATAS switches to M1 data.
REQ-049 HRESET pulsed while M1 in WAIT -> all outputs at REQ-042 values immediately; no M1 transfer after release.

Source files
------------

// File: rtl/cmsdk_ahb_sram_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single SRAM slave port.
// A losing address phase is parked in a per-master pending register and replayed later.
module cmsdk_ahb_sram_arbiter #(
   parameter int unsigned AW          = 16,
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic [1:0]      HSELM,
   input  logic [2*AW-1:0] HADDRM,
   input  logic [3:0]      HTRANSM,
   input  logic [5:0]      HSIZEM,
   input  logic [1:0]      HWRITEM,
   input  logic [63:0]     HWDATAM,
   input  logic [1:0]      HREADYM,
   output logic [1:0]      HREADYOUTM,
   output logic [63:0]     HRDATAM,
   output logic [1:0]      HRESPM,
   output logic            HSELS,
   output logic [AW-1:0]   HADDRS,
   output logic [1:0]      HTRANSS,
   output logic [2:0]      HSIZES,
   output logic            HWRITES,
   output logic [31:0]     HWDATAS,
   output logic            HREADYS,
   input  logic            HREADYOUTS,
   input  logic [31:0]     HRDATAS,
   input  logic            HRESPS
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t        state [2];
   logic [AW-1:0] pend_addr [2];
   logic [2:0]    pend_size [2];
   logic [1:0]    pend_write;
   logic          last_grant;
   logic [1:0]    live;
   logic [1:0]    req;
   logic [1:0]    gnt;
   logic          unused_trans;

   // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY.
   assign unused_trans = ^{HTRANSM[2], HTRANSM[0]};

   always_comb begin
      live = '0;
      req  = '0;
      for (int i = 0; i < 2; i++) begin
         live[i] = HSELM[i] & HTRANSM[2*i+1] & HREADYM[i];
         req[i]  = live[i] | (state[i] == S_WAIT);
      end
   end

   // Grants are suppressed under reset so live inputs cannot leak onto the slave.
   always_comb begin
      gnt = 2'b00;
      if (!HRESET && HREADYOUTS) begin
         if (req == 2'b11) begin
            gnt = (ROUND_ROBIN != 0 && !last_grant) ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
      end
   end

   always_comb begin
      HSELS   = |gnt;
      HTRANSS = (|gnt) ? 2'b10 : 2'b00;
      if (gnt[1]) begin
         HADDRS  = (state[1] == S_WAIT) ? pend_addr[1]  : HADDRM[2*AW-1:AW];
         HSIZES  = (state[1] == S_WAIT) ? pend_size[1]  : HSIZEM[5:3];
         HWRITES = (state[1] == S_WAIT) ? pend_write[1] : HWRITEM[1];
      end else begin
         HADDRS  = (state[0] == S_WAIT) ? pend_addr[0]  : HADDRM[AW-1:0];
         HSIZES  = (state[0] == S_WAIT) ? pend_size[0]  : HSIZEM[2:0];
         HWRITES = (state[0] == S_WAIT) ? pend_write[0] : HWRITEM[0];
      end
   end

   always_comb begin
      if (state[0] == S_DATA) begin
         HWDATAS = HWDATAM[31:0];
      end else if (state[1] == S_DATA) begin
         HWDATAS = HWDATAM[63:32];
      end else begin
         HWDATAS = 32'h0;
      end
   end

   // Master-side responses depend only on state, never on the grant.
   always_comb begin
      HREADYOUTM = 2'b11;
      HRESPM     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         case (state[i])
            S_IDLE:  HREADYOUTM[i] = 1'b1;
            S_WAIT:  HREADYOUTM[i] = 1'b0;
            default: HREADYOUTM[i] = HREADYOUTS;
         endcase
         HRESPM[i] = (state[i] == S_DATA) & HRESPS;
      end
   end

   assign HREADYS = HREADYOUTS;
   assign HRDATAM = {HRDATAS, HRDATAS};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int i = 0; i < 2; i++) begin
            state[i]     <= S_IDLE;
            pend_addr[i] <= '0;
            pend_size[i] <= '0;
         end
         pend_write <= '0;
         last_grant <= 1'b1;
      end else begin
         if (|gnt) begin
            last_grant <= gnt[1];
         end
         for (int i = 0; i < 2; i++) begin
            if (live[i] && !gnt[i]) begin
               pend_addr[i]  <= HADDRM[i*AW +: AW];
               pend_size[i]  <= HSIZEM[3*i +: 3];
               pend_write[i] <= HWRITEM[i];
            end
            case (state[i])
               S_IDLE: begin
                  if (live[i]) state[i] <= gnt[i] ? S_DATA : S_WAIT;
               end
               S_WAIT: begin
                  if (gnt[i]) state[i] <= S_DATA;
               end
               S_DATA: begin
                  if (HREADYOUTS) begin
                     if (!live[i])    state[i] <= S_IDLE;
                     else if (gnt[i]) state[i] <= S_DATA;
                     else             state[i] <= S_WAIT;
                  end
               end
               default: state[i] <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cmsdk_ahb_sram_arbiter.sv
// Directed bench for cmsdk_ahb_sram_arbiter: per-cycle vector table on a round-robin
// instance, plus hand sequences for fixed priority and reset during a parked request.
module tb_cmsdk_ahb_sram_arbiter;

   localparam int unsigned AW = 16;
   localparam logic [1:0] T_ID = 2'b00;
   localparam logic [1:0] T_BY = 2'b01;
   localparam logic [1:0] T_NS = 2'b10;
   localparam logic [1:0] T_SQ = 2'b11;

   typedef struct {
      logic        rst;
      logic [1:0]  sel;
      logic [3:0]  trans;
      logic [15:0] a0;
      logic [15:0] a1;
      logic [1:0]  wr;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic        ry;
      logic        rsp;
      logic [31:0] rd;
      logic [1:0]  e_ry;
      logic [1:0]  e_rsp;
      logic        e_sels;
      logic [1:0]  e_tr;
      logic [15:0] e_addr;
      logic        e_wr;
      logic [31:0] e_wd;
   } vec_t;

   logic            hclk;
   logic            hreset;
   logic [1:0]      hselm;
   logic [2*AW-1:0] haddrm;
   logic [3:0]      htransm;
   logic [5:0]      hsizem;
   logic [1:0]      hwritem;
   logic [63:0]     hwdatam;
   logic [1:0]      hreadym;
   logic [1:0]      hreadyoutm;
   logic [63:0]     hrdatam;
   logic [1:0]      hrespm;
   logic            hsels;
   logic [AW-1:0]   haddrs;
   logic [1:0]      htranss;
   logic [2:0]      hsizes;
   logic            hwrites;
   logic [31:0]     hwdatas;
   logic            hreadys;
   logic            hreadyouts;
   logic [31:0]     hrdatas;
   logic            hresps;

   logic [1:0]      hreadym_fp;
   logic [1:0]      hreadyoutm_fp;
   logic            hsels_fp;
   logic [AW-1:0]   haddrs_fp;
   logic [1:0]      htranss_fp;
   logic [63:0]     unused_fp_rdata;
   logic [1:0]      unused_fp_resp;
   logic [2:0]      unused_fp_size;
   logic            unused_fp_write;
   logic [31:0]     unused_fp_wdata;
   logic            unused_fp_ready;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   // Each master's bus HREADY is its own HREADYOUT, as at system level.
   assign hreadym    = hreadyoutm;
   assign hreadym_fp = hreadyoutm_fp;

   cmsdk_ahb_sram_arbiter #(.AW(AW), .ROUND_ROBIN(1)) dut (
      .HCLK(hclk), .HRESET(hreset), .HSELM(hselm), .HADDRM(haddrm), .HTRANSM(htransm),
      .HSIZEM(hsizem), .HWRITEM(hwritem), .HWDATAM(hwdatam), .HREADYM(hreadym),
      .HREADYOUTM(hreadyoutm), .HRDATAM(hrdatam), .HRESPM(hrespm), .HSELS(hsels),
      .HADDRS(haddrs), .HTRANSS(htranss), .HSIZES(hsizes), .HWRITES(hwrites),
      .HWDATAS(hwdatas), .HREADYS(hreadys), .HREADYOUTS(hreadyouts),
      .HRDATAS(hrdatas), .HRESPS(hresps)
   );

   cmsdk_ahb_sram_arbiter #(.AW(AW), .ROUND_ROBIN(0)) dut_fp (
      .HCLK(hclk), .HRESET(hreset), .HSELM(hselm), .HADDRM(haddrm), .HTRANSM(htransm),
      .HSIZEM(hsizem), .HWRITEM(hwritem), .HWDATAM(hwdatam), .HREADYM(hreadym_fp),
      .HREADYOUTM(hreadyoutm_fp), .HRDATAM(unused_fp_rdata), .HRESPM(unused_fp_resp),
      .HSELS(hsels_fp), .HADDRS(haddrs_fp), .HTRANSS(htranss_fp), .HSIZES(unused_fp_size),
      .HWRITES(unused_fp_write), .HWDATAS(unused_fp_wdata), .HREADYS(unused_fp_ready),
      .HREADYOUTS(hreadyouts), .HRDATAS(hrdatas), .HRESPS(hresps)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   function automatic vec_t mk(
      input logic rst, input logic [1:0] sel, input logic [3:0] trans,
      input logic [15:0] a0, input logic [15:0] a1, input logic [1:0] wr,
      input logic [31:0] wd0, input logic [31:0] wd1, input logic ry, input logic rsp,
      input logic [31:0] rd, input logic [1:0] e_ry, input logic [1:0] e_rsp,
      input logic e_sels, input logic [1:0] e_tr, input logic [15:0] e_addr,
      input logic e_wr, input logic [31:0] e_wd);
      vec_t v;
      v.rst = rst;   v.sel = sel;     v.trans = trans;   v.a0 = a0;       v.a1 = a1;
      v.wr = wr;     v.wd0 = wd0;     v.wd1 = wd1;       v.ry = ry;       v.rsp = rsp;
      v.rd = rd;     v.e_ry = e_ry;   v.e_rsp = e_rsp;   v.e_sels = e_sels;
      v.e_tr = e_tr; v.e_addr = e_addr; v.e_wr = e_wr;   v.e_wd = e_wd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_bus(input logic [1:0] sel, input logic [3:0] trans, input logic [15:0] a0,
                          input logic [15:0] a1, input logic [31:0] wd0, input logic ry,
                          input logic rsp);
      hselm      = sel;
      htransm    = trans;
      haddrm     = {a1, a0};
      hwdatam    = {32'h0, wd0};
      hreadyouts = ry;
      hresps     = rsp;
   endtask

   initial begin
      hreset  = 1'b1;
      hsizem  = 6'b010_010;
      hwritem = 2'b00;
      hrdatas = 32'h0;
      set_bus(2'b00, {T_ID, T_ID}, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0);
      repeat (2) @(posedge hclk);

      // Zero-wait single read, then reset and a simultaneous request from both masters.
      tbl.push_back(mk(1, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0,        2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(0, 2'b01, {T_ID,T_NS}, 16'h0100, 16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0,        2'b11, 2'b00, 1, T_NS, 16'h0100, 0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'hCAFE0001, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0,        2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(1, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0,        2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(0, 2'b11, {T_NS,T_NS}, 16'h0200, 16'h0300, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0,        2'b11, 2'b00, 1, T_NS, 16'h0200, 0, 32'h0));
      tbl.push_back(mk(0, 2'b10, {T_NS,T_ID}, 16'h0,    16'h0BAD, 2'b00, 32'h0, 32'h0, 1, 0, 32'h12345678, 2'b01, 2'b00, 1, T_NS, 16'h0300, 0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h9ABCDEF0, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      // M0 write stretched by two slave wait states while M1 parks its write.
      tbl.push_back(mk(0, 2'b01, {T_ID,T_NS}, 16'h0400, 16'h0,    2'b01, 32'h0,        32'h0,        1, 0, 32'h0, 2'b11, 2'b00, 0+1, T_NS, 16'h0400, 1, 32'h0));
      tbl.push_back(mk(0, 2'b10, {T_NS,T_ID}, 16'h0,    16'h0500, 2'b10, 32'hD0D00000, 32'h0,        0, 0, 32'h0, 2'b10, 2'b00, 0, T_ID, 16'h0,    0, 32'hD0D00000));
      tbl.push_back(mk(0, 2'b10, {T_NS,T_ID}, 16'h0,    16'h0500, 2'b10, 32'hD0D00000, 32'h11111111, 0, 0, 32'h0, 2'b00, 2'b00, 0, T_ID, 16'h0,    0, 32'hD0D00000));
      tbl.push_back(mk(0, 2'b10, {T_NS,T_ID}, 16'h0,    16'h0500, 2'b10, 32'hD0D00000, 32'h11111111, 1, 0, 32'h0, 2'b01, 2'b00, 1, T_NS, 16'h0500, 1, 32'hD0D00000));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0,        32'hE1E10000, 1, 0, 32'h0, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'hE1E10000));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0,        32'h0,        1, 0, 32'h0, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      // Two concurrent 4-beat bursts: grants alternate, SEQ becomes NONSEQ.
      tbl.push_back(mk(0, 2'b11, {T_NS,T_NS}, 16'h1000, 16'h2000, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b11, 2'b00, 1, T_NS, 16'h1000, 0, 32'h0));
      tbl.push_back(mk(0, 2'b11, {T_SQ,T_SQ}, 16'h1004, 16'h2004, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b01, 2'b00, 1, T_NS, 16'h2000, 0, 32'h0));
      tbl.push_back(mk(0, 2'b11, {T_SQ,T_SQ}, 16'h1008, 16'h2004, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b10, 2'b00, 1, T_NS, 16'h1004, 0, 32'h0));
      tbl.push_back(mk(0, 2'b11, {T_SQ,T_SQ}, 16'h1008, 16'h2008, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b01, 2'b00, 1, T_NS, 16'h2004, 0, 32'h0));
      tbl.push_back(mk(0, 2'b11, {T_SQ,T_SQ}, 16'h100C, 16'h2008, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b10, 2'b00, 1, T_NS, 16'h1008, 0, 32'h0));
      tbl.push_back(mk(0, 2'b11, {T_SQ,T_SQ}, 16'h100C, 16'h200C, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b01, 2'b00, 1, T_NS, 16'h2008, 0, 32'h0));
      tbl.push_back(mk(0, 2'b10, {T_SQ,T_ID}, 16'h0,    16'h200C, 2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b10, 2'b00, 1, T_NS, 16'h100C, 0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b01, 2'b00, 1, T_NS, 16'h200C, 0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      // BUSY is ignored; a two-cycle ERROR response reaches only the master in data phase.
      tbl.push_back(mk(0, 2'b01, {T_ID,T_BY}, 16'h0600, 16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(0, 2'b01, {T_ID,T_NS}, 16'h0700, 16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b11, 2'b00, 1, T_NS, 16'h0700, 0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 0, 1, 32'h0, 2'b10, 2'b01, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 1, 32'h0, 2'b11, 2'b01, 0, T_ID, 16'h0,    0, 32'h0));
      tbl.push_back(mk(0, 2'b00, {T_ID,T_ID}, 16'h0,    16'h0,    2'b00, 32'h0, 32'h0, 1, 0, 32'h0, 2'b11, 2'b00, 0, T_ID, 16'h0,    0, 32'h0));

      foreach (tbl[k]) begin
         @(posedge hclk);
         #1;
         hreset     = tbl[k].rst;
         hselm      = tbl[k].sel;
         htransm    = tbl[k].trans;
         haddrm     = {tbl[k].a1, tbl[k].a0};
         hwritem    = tbl[k].wr;
         hwdatam    = {tbl[k].wd1, tbl[k].wd0};
         hreadyouts = tbl[k].ry;
         hresps     = tbl[k].rsp;
         hrdatas    = tbl[k].rd;
         @(negedge hclk);
         chk($sformatf("v%0d readyoutm", k), 32'(hreadyoutm), 32'(tbl[k].e_ry));
         chk($sformatf("v%0d respm", k),     32'(hrespm),     32'(tbl[k].e_rsp));
         chk($sformatf("v%0d sels", k),      32'(hsels),      32'(tbl[k].e_sels));
         chk($sformatf("v%0d transs", k),    32'(htranss),    32'(tbl[k].e_tr));
         chk($sformatf("v%0d wdatas", k),    hwdatas,         tbl[k].e_wd);
         chk($sformatf("v%0d readys", k),    32'(hreadys),    32'(tbl[k].ry));
         chk($sformatf("v%0d rdatam0", k),   hrdatam[31:0],   tbl[k].rd);
         chk($sformatf("v%0d rdatam1", k),   hrdatam[63:32],  tbl[k].rd);
         if (tbl[k].e_sels) begin
            chk($sformatf("v%0d addrs", k),  32'(haddrs),  32'(tbl[k].e_addr));
            chk($sformatf("v%0d writes", k), 32'(hwrites), 32'(tbl[k].e_wr));
            chk($sformatf("v%0d sizes", k),  32'(hsizes),  32'(3'b010));
         end
      end

      // Fixed priority: M1 parks until M0 stops requesting.
      @(posedge hclk); #1;
      hreset  = 1'b1;
      hwritem = 2'b00;
      set_bus(2'b00, {T_ID, T_ID}, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0);
      @(posedge hclk); #1;
      hreset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         set_bus(2'b11, {T_NS, T_NS}, 16'(16'h3000 + 4*c), 16'h4000, 32'h0, 1'b1, 1'b0);
         @(negedge hclk);
         chk($sformatf("fp c%0d sels", c),      32'(hsels_fp),      32'h1);
         chk($sformatf("fp c%0d transs", c),    32'(htranss_fp),    32'(T_NS));
         chk($sformatf("fp c%0d addrs", c),     32'(haddrs_fp),     32'(16'h3000 + 4*c));
         chk($sformatf("fp c%0d readyoutm", c), 32'(hreadyoutm_fp), (c == 0) ? 32'h3 : 32'h1);
         @(posedge hclk); #1;
      end
      set_bus(2'b10, {T_NS, T_ID}, 16'h0, 16'h4000, 32'h0, 1'b1, 1'b0);
      @(negedge hclk);
      chk("fp m1 sels",      32'(hsels_fp),      32'h1);
      chk("fp m1 addrs",     32'(haddrs_fp),     32'h4000);
      chk("fp m1 readyoutm", 32'(hreadyoutm_fp), 32'h1);
      @(posedge hclk); #1;
      set_bus(2'b00, {T_ID, T_ID}, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0);
      @(negedge hclk);
      chk("fp end sels",      32'(hsels_fp),      32'h0);
      chk("fp end readyoutm", 32'(hreadyoutm_fp), 32'h3);

      // Reset asserted between clock edges while M1 is parked.
      @(posedge hclk); #1;
      hreset = 1'b1;
      @(posedge hclk); #1;
      hreset = 1'b0;
      set_bus(2'b11, {T_NS, T_NS}, 16'h5000, 16'h5100, 32'h0, 1'b1, 1'b0);
      @(negedge hclk);
      chk("rst pre sels",  32'(hsels),  32'h1);
      chk("rst pre addrs", 32'(haddrs), 32'h5000);
      @(posedge hclk); #1;
      set_bus(2'b10, {T_NS, T_ID}, 16'h0, 16'h5100, 32'hA5A5A5A5, 1'b0, 1'b1);
      @(negedge hclk);
      chk("rst wait readyoutm", 32'(hreadyoutm), 32'h0);
      chk("rst wait wdatas",    hwdatas,         32'hA5A5A5A5);
      chk("rst wait respm",     32'(hrespm),     32'h1);
      #1;
      hreset = 1'b1;
      #1;
      chk("rst async readyoutm", 32'(hreadyoutm), 32'h3);
      chk("rst async respm",     32'(hrespm),     32'h0);
      chk("rst async sels",      32'(hsels),      32'h0);
      chk("rst async transs",    32'(htranss),    32'h0);
      chk("rst async wdatas",    hwdatas,         32'h0);
      @(posedge hclk); #1;
      hreset = 1'b0;
      set_bus(2'b00, {T_ID, T_ID}, 16'h0, 16'h0, 32'h0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         @(negedge hclk);
         chk($sformatf("rst post c%0d sels", c),      32'(hsels),      32'h0);
         chk($sformatf("rst post c%0d readyoutm", c), 32'(hreadyoutm), 32'h3);
         @(posedge hclk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
